// File: rtl/echo_pkg.sv
// echo_pkg: shared types and default widths for the echo boxcar integrator.
package echo_pkg;

  localparam int unsigned ADC_W_DEF  = 12;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned SHOT_W_DEF = 16;
  localparam int unsigned NSAMP_W    = 32;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StWaitGate,
    StIntegrate,
    StDone,
    StHold
  } echo_state_e;

endpackage

// File: rtl/echo_accum.sv
// echo_accum: signed accumulator with sample counter, synchronous clear and a
// sticky flag raised on signed overflow of the sum or wrap of the counter.
module echo_accum
  import echo_pkg::*;
#(
  parameter int unsigned IN_W  = ADC_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic                    clk_pll,
  input  logic                    resetn,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] acc,
  output logic [NSAMP_W-1:0]      cnt,
  output logic                    ovf
);

  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic                    add_ovf;
  logic                    cnt_wrap;

  // Sign-extend the sample and detect two's-complement overflow of the add.
  always_comb begin
    addend   = ACC_W'(din);
    sum      = acc + addend;
    add_ovf  = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    cnt_wrap = &cnt;
  end

  // Accumulate on enable; sum and count wrap, overflow stays set until clear.
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (en) begin
      acc <= sum;
      cnt <= cnt + NSAMP_W'(1);
      if (add_ovf || cnt_wrap) begin
        ovf <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/echo_boxcar.sv
// echo_boxcar: integrates ADC samples over each record_start gate window,
// sums a configurable number of shots and hands the total out over
// valid/ready. Define ECHO_BASELINE_EN to also accumulate the off-gate
// baseline between shots (adds baseline_out and nbase_out).
module echo_boxcar
  import echo_pkg::*;
#(
  parameter int unsigned ADC_W  = ADC_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned SHOT_W = SHOT_W_DEF
) (
  input  logic                    clk_pll,
  input  logic                    resetn,
  input  logic                    arm,
  input  logic [SHOT_W-1:0]       nshots,
  input  logic                    record_start,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    adc_valid,
  output logic                    busy,
  output logic signed [ACC_W-1:0] sum_out,
  output logic [NSAMP_W-1:0]      nsamp_out,
  output logic                    result_valid,
  input  logic                    result_ready,
`ifdef ECHO_BASELINE_EN
  output logic signed [ACC_W-1:0] baseline_out,
  output logic [NSAMP_W-1:0]      nbase_out,
`endif
  output logic                    overflow
);

  echo_state_e             state_q;
  logic                    gate_q;
  logic [SHOT_W-1:0]       nshots_lat;
  logic [SHOT_W-1:0]       shot_cnt;
  logic [SHOT_W-1:0]       shot_next;
  logic                    gate_rise;
  logic                    gate_fall;
  logic                    arm_take;
  logic                    acc_en;
  logic signed [ACC_W-1:0] acc_sum;
  logic [NSAMP_W-1:0]      acc_cnt;
  logic                    acc_ovf;

  // Edge detect on the gate and the accumulate qualifiers.
  always_comb begin
    gate_rise = record_start & ~gate_q;
    gate_fall = ~record_start & gate_q;
    arm_take  = arm && (state_q == StIdle);
    shot_next = shot_cnt + SHOT_W'(1);
    // The rising-edge cycle is still in WaitGate but its sample belongs to the window.
    acc_en    = adc_valid && record_start &&
                (((state_q == StWaitGate) && gate_rise) || (state_q == StIntegrate));
  end

  echo_accum #(
    .IN_W  (ADC_W),
    .ACC_W (ACC_W)
  ) u_accum (
    .clk_pll (clk_pll),
    .resetn  (resetn),
    .clr     (arm_take),
    .en      (acc_en),
    .din     (adc_data),
    .acc     (acc_sum),
    .cnt     (acc_cnt),
    .ovf     (acc_ovf)
  );

  // Acquisition sequencer with registered handshake and result outputs.
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      state_q      <= StIdle;
      gate_q       <= 1'b0;
      nshots_lat   <= '0;
      shot_cnt     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      sum_out      <= '0;
      nsamp_out    <= '0;
    end else begin
      gate_q <= record_start;
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            nshots_lat <= (nshots == '0) ? SHOT_W'(1) : nshots;
            shot_cnt   <= '0;
            busy       <= 1'b1;
            // Arming mid-window would integrate a truncated shot, so skip it.
            state_q    <= record_start ? StSync : StWaitGate;
          end
        end
        StSync: begin
          if (!record_start) begin
            state_q <= StWaitGate;
          end
        end
        StWaitGate: begin
          if (gate_rise) begin
            state_q <= StIntegrate;
          end
        end
        StIntegrate: begin
          if (gate_fall) begin
            shot_cnt <= shot_next;
            state_q  <= (shot_next == nshots_lat) ? StDone : StWaitGate;
          end
        end
        StDone: begin
          sum_out      <= acc_sum;
          nsamp_out    <= acc_cnt;
          result_valid <= 1'b1;
          state_q      <= StHold;
        end
        StHold: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ECHO_BASELINE_EN
  logic                    base_en;
  logic signed [ACC_W-1:0] base_sum;
  logic [NSAMP_W-1:0]      base_cnt;
  logic                    base_ovf;

  // Off-gate samples between shots form the baseline estimate.
  always_comb begin
    base_en = adc_valid && !record_start && (state_q == StWaitGate) && (shot_cnt != '0);
  end

  echo_accum #(
    .IN_W  (ADC_W),
    .ACC_W (ACC_W)
  ) u_base (
    .clk_pll (clk_pll),
    .resetn  (resetn),
    .clr     (arm_take),
    .en      (base_en),
    .din     (adc_data),
    .acc     (base_sum),
    .cnt     (base_cnt),
    .ovf     (base_ovf)
  );

  // Baseline results are published alongside sum_out and cleared on arm.
  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      baseline_out <= '0;
      nbase_out    <= '0;
    end else if (arm_take) begin
      baseline_out <= '0;
      nbase_out    <= '0;
    end else if (state_q == StDone) begin
      baseline_out <= base_sum;
      nbase_out    <= base_cnt;
    end
  end

  // A wrapped baseline is as untrustworthy as a wrapped signal sum.
  assign overflow = acc_ovf | base_ovf;
`else
  assign overflow = acc_ovf;
`endif

endmodule

// File: tb/tb_echo_boxcar.sv
// tb_echo_boxcar: randomized and directed traces for echo_boxcar, checked
// against a trace-level model of gate windows and shot counting. A second
// instance with a 14-bit accumulator runs the same stimulus for wrap cases.
module tb_echo_boxcar;

  logic               clk_pll = 1'b0;
  logic               resetn;
  logic               arm;
  logic [15:0]        nshots;
  logic               record_start;
  logic signed [11:0] adc_data;
  logic               adc_valid;
  logic               result_ready;

  logic               busy, result_valid, overflow;
  logic signed [39:0] sum_out;
  logic [31:0]        nsamp_out;
  logic               n_busy, n_result_valid, n_overflow;
  logic signed [13:0] n_sum_out;
  logic [31:0]        n_nsamp_out;
`ifdef ECHO_BASELINE_EN
  logic signed [39:0] baseline_out;
  logic [31:0]        nbase_out;
  logic signed [13:0] n_baseline_out;
  logic [31:0]        n_nbase_out;
`endif

  int errors = 0;
  int checks = 0;

  bit tr_arm[$];
  bit tr_gate[$];
  bit tr_valid[$];
  int tr_data[$];

  always #5 clk_pll = ~clk_pll;

  echo_boxcar dut (
    .clk_pll      (clk_pll),
    .resetn       (resetn),
    .arm          (arm),
    .nshots       (nshots),
    .record_start (record_start),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .busy         (busy),
    .sum_out      (sum_out),
    .nsamp_out    (nsamp_out),
    .result_valid (result_valid),
    .result_ready (result_ready),
`ifdef ECHO_BASELINE_EN
    .baseline_out (baseline_out),
    .nbase_out    (nbase_out),
`endif
    .overflow     (overflow)
  );

  echo_boxcar #(
    .ACC_W (14)
  ) dut_narrow (
    .clk_pll      (clk_pll),
    .resetn       (resetn),
    .arm          (arm),
    .nshots       (nshots),
    .record_start (record_start),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .busy         (n_busy),
    .sum_out      (n_sum_out),
    .nsamp_out    (n_nsamp_out),
    .result_valid (n_result_valid),
    .result_ready (result_ready),
`ifdef ECHO_BASELINE_EN
    .baseline_out (n_baseline_out),
    .nbase_out    (n_nbase_out),
`endif
    .overflow     (n_overflow)
  );

  task automatic tr_clear();
    tr_arm.delete(); tr_gate.delete(); tr_valid.delete(); tr_data.delete();
  endtask

  task automatic tr_push(input bit a, input bit g, input bit v, input int d);
    tr_arm.push_back(a); tr_gate.push_back(g); tr_valid.push_back(v); tr_data.push_back(d);
  endtask

  task automatic drive_idle();
    arm = 1'b0; record_start = 1'b0; adc_valid = 1'b0; adc_data = '0;
  endtask

  task automatic drive_entry(input int i, input int nsh);
    arm = tr_arm[i]; nshots = 16'(nsh); record_start = tr_gate[i];
    adc_valid = tr_valid[i]; adc_data = 12'(tr_data[i]);
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Two's-complement add in an accw-bit register; o flags a signed wrap.
  function automatic longint wrap_add(input longint a, input int d, input int accw,
                                      output bit o);
    longint span = longint'(1) << accw;
    longint hi = (longint'(1) << (accw - 1)) - 1;
    longint lo = -(longint'(1) << (accw - 1));
    longint x = a + longint'(d);
    o = 1'b0;
    if (x > hi) begin x = x - span; o = 1'b1; end
    else if (x < lo) begin x = x + span; o = 1'b1; end
    return x;
  endfunction

  // Walk the trace as gate windows: a window open at arm is discarded, each
  // later high run is one shot, low samples between shots form the baseline.
  function automatic void model(input int nsh, input int accw, output longint sum,
                                output int nsamp, output bit ovf, output longint base,
                                output int nbase, output int last_fall);
    int n = (nsh == 0) ? 1 : nsh;
    int shots = 0;
    bit in_win = 1'b0;
    int i = 0;
    bit o;
    sum = 0; nsamp = 0; ovf = 1'b0; base = 0; nbase = 0; last_fall = -1;
    if (tr_gate[0]) while (i < tr_gate.size() && tr_gate[i]) i++;
    for (; i < tr_gate.size() && shots < n; i++) begin
      if (tr_gate[i]) begin
        in_win = 1'b1;
        if (tr_valid[i]) begin
          sum = wrap_add(sum, tr_data[i], accw, o);
          ovf |= o;
          nsamp++;
        end
      end else if (in_win) begin
        in_win = 1'b0;
        shots++;
        if (shots == n) last_fall = i;
      end else if (shots > 0 && tr_valid[i]) begin
        base = wrap_add(base, tr_data[i], accw, o);
`ifdef ECHO_BASELINE_EN
        ovf |= o;
`endif
        nbase++;
      end
    end
  endfunction

  // Drive the current trace with arm on entry 0, then check result, hold and accept.
  task automatic run_trace(input int nsh, input bit hold_gate, input string name);
    longint esum, ebase, nsum, nbase_e;
    int ensamp, enbase, elast, nn, nb, nl;
    bit eovf, novf;
    int first_rv = -1;
    int tr_len = tr_gate.size();
    int nhold;
    model(nsh, 40, esum, ensamp, eovf, ebase, enbase, elast);
    model(nsh, 14, nsum, nn, novf, nbase_e, nb, nl);
    for (int i = 0; i < tr_len + 40; i++) begin
      @(negedge clk_pll);
      if (result_valid && first_rv < 0) first_rv = i;
      if (i == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy_after_arm: got %b want 1", name, busy);
        end
      end
      if (first_rv >= 0 && i >= tr_len) break;
      if (i < tr_len) drive_entry(i, nsh);
      else drive_idle();
    end
    drive_idle();
    checks++;
    if (first_rv != elast + 2) begin
      errors++;
      $display("FAIL %s result_latency: got cycle %0d want %0d", name, first_rv, elast + 2);
      if (first_rv < 0) return;
    end
    checks += 5;
    if (sum_out !== esum[39:0]) begin
      errors++; $display("FAIL %s sum_out: got %0d want %0d", name, sum_out, esum);
    end
    if (nsamp_out !== 32'(ensamp)) begin
      errors++; $display("FAIL %s nsamp_out: got %0d want %0d", name, nsamp_out, ensamp);
    end
    if (overflow !== eovf) begin
      errors++; $display("FAIL %s overflow: got %b want %b", name, overflow, eovf);
    end
    if (n_sum_out !== nsum[13:0]) begin
      errors++; $display("FAIL %s narrow_sum: got %0d want %0d", name, n_sum_out, nsum);
    end
    if (n_overflow !== novf) begin
      errors++; $display("FAIL %s narrow_overflow: got %b want %b", name, n_overflow, novf);
    end
`ifdef ECHO_BASELINE_EN
    checks += 2;
    if (baseline_out !== ebase[39:0]) begin
      errors++; $display("FAIL %s baseline_out: got %0d want %0d", name, baseline_out, ebase);
    end
    if (nbase_out !== 32'(enbase)) begin
      errors++; $display("FAIL %s nbase_out: got %0d want %0d", name, nbase_out, enbase);
    end
`endif
    nhold = $urandom_range(2, 5);
    for (int h = 0; h < nhold; h++) begin
      @(negedge clk_pll);
      if (hold_gate) begin
        record_start = 1'b1; adc_valid = 1'b1; adc_data = 12'(rand_sample());
      end
    end
    @(negedge clk_pll);
    drive_idle();
    checks += 4;
    if (result_valid !== 1'b1) begin
      errors++; $display("FAIL %s valid_held: got %b want 1", name, result_valid);
    end
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_held: got %b want 1", name, busy);
    end
    if (sum_out !== esum[39:0]) begin
      errors++; $display("FAIL %s sum_stable: got %0d want %0d", name, sum_out, esum);
    end
    if (nsamp_out !== 32'(ensamp)) begin
      errors++; $display("FAIL %s nsamp_stable: got %0d want %0d", name, nsamp_out, ensamp);
    end
    result_ready = 1'b1;
    @(negedge clk_pll);
    result_ready = 1'b0;
    checks += 2;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL %s valid_after_accept: got %b want 0", name, result_valid);
    end
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_after_accept: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; result_ready = 1'b0; nshots = '0;
    drive_idle();
    repeat (3) @(negedge clk_pll);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL reset result_valid: got %b want 0", result_valid);
    end
    if (sum_out !== '0) begin errors++; $display("FAIL reset sum_out: got %0d want 0", sum_out); end
    if (nsamp_out !== '0) begin
      errors++; $display("FAIL reset nsamp_out: got %0d want 0", nsamp_out);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL reset overflow: got %b want 0", overflow);
    end
    resetn = 1'b1;
    @(negedge clk_pll);
  endtask

  task automatic test_single_shot();
    tr_clear();
    tr_push(1, 0, 0, 0);
    repeat (10) tr_push(0, 1, 1, 3);
    repeat (2) tr_push(0, 0, 0, 0);
    run_trace(1, 0, "single_shot");
  endtask

  task automatic test_multi_shot();
    tr_clear();
    tr_push(1, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      repeat (5) tr_push(0, 1, 1, -2);
      repeat (3) tr_push(0, 0, 0, 0);
    end
    run_trace(4, 0, "multi_shot");
  endtask

  task automatic test_sync_discard();
    tr_clear();
    tr_push(1, 1, 1, 7);
    repeat (3) tr_push(0, 1, 1, 7);
    repeat (3) tr_push(0, 0, 0, 0);
    repeat (8) tr_push(0, 1, 1, 1);
    repeat (2) tr_push(0, 0, 0, 0);
    run_trace(1, 0, "sync_discard");
  endtask

  task automatic test_valid_toggle();
    tr_clear();
    tr_push(1, 0, 0, 0);
    for (int c = 0; c < 10; c++) tr_push(0, 1, c[0] == 1'b0, 5);
    repeat (2) tr_push(0, 0, 0, 0);
    run_trace(1, 1, "valid_toggle_hold_gate");
  endtask

  task automatic test_overflow();
    tr_clear();
    tr_push(1, 0, 0, 0);
    repeat (5) tr_push(0, 1, 1, 2047);
    repeat (2) tr_push(0, 0, 0, 0);
    run_trace(1, 0, "overflow");
  endtask

  task automatic test_zero_window();
    tr_clear();
    tr_push(1, 0, 0, 0);
    repeat (3) tr_push(0, 1, 0, 9);
    repeat (2) tr_push(0, 0, 0, 0);
    repeat (4) tr_push(0, 1, 1, -6);
    repeat (2) tr_push(0, 0, 0, 0);
    run_trace(2, 0, "zero_window");
    tr_clear();
    tr_push(1, 0, 0, 0);
    repeat (3) tr_push(0, 1, 1, 11);
    repeat (2) tr_push(0, 0, 0, 0);
    run_trace(0, 0, "nshots_zero");
  endtask

  task automatic test_baseline();
    tr_clear();
    tr_push(1, 0, 0, 0);
    repeat (3) tr_push(0, 1, 1, 2);
    repeat (5) tr_push(0, 0, 1, 1);
    repeat (3) tr_push(0, 1, 1, 2);
    repeat (2) tr_push(0, 0, 1, 1);
    run_trace(2, 0, "baseline");
  endtask

  task automatic test_reset_mid();
    tr_clear();
    tr_push(1, 0, 0, 0);
    repeat (6) tr_push(0, 1, 1, 4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_pll);
      drive_entry(i, 1);
    end
    @(negedge clk_pll);
    resetn = 1'b0;
    @(negedge clk_pll);
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset busy: got %b want 0", busy); end
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset result_valid: got %b want 0", result_valid);
    end
    if (sum_out !== '0) begin
      errors++; $display("FAIL mid_reset sum_out: got %0d want 0", sum_out);
    end
    if (nsamp_out !== '0) begin
      errors++; $display("FAIL mid_reset nsamp_out: got %0d want 0", nsamp_out);
    end
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL mid_reset overflow: got %b want 0", overflow);
    end
    resetn = 1'b1;
    drive_idle();
    @(negedge clk_pll);
    tr_clear();
    tr_push(1, 0, 0, 0);
    repeat (4) tr_push(0, 1, 1, -9);
    repeat (2) tr_push(0, 0, 0, 0);
    run_trace(1, 0, "after_mid_reset");
  endtask

  // Random windows, gaps, valids, data and stray arm pulses that must be ignored.
  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      int nsh = $urandom_range(0, 3);
      int lead = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      int nw = (nsh == 0) ? 1 : nsh;
      tr_clear();
      tr_push(1, lead > 0, $urandom_range(0, 1) == 1, rand_sample());
      for (int l = 1; l < lead; l++) tr_push(0, 1, $urandom_range(0, 1) == 1, rand_sample());
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) tr_push(0, 0, 0, 0);
      for (int w = 0; w < nw; w++) begin
        int wl = $urandom_range(1, 6);
        int gl = $urandom_range(1, 4);
        for (int c = 0; c < wl; c++)
          tr_push($urandom_range(0, 7) == 0, 1, $urandom_range(0, 3) != 0, rand_sample());
        for (int c = 0; c < gl; c++)
          tr_push($urandom_range(0, 7) == 0, 0, $urandom_range(0, 1) == 1, rand_sample());
      end
      tr_push(0, 0, 0, 0);
      run_trace(nsh, $urandom_range(0, 1) == 1, $sformatf("random%0d", it));
    end
  endtask

  initial begin
    test_reset();
    test_single_shot();
    test_multi_shot();
    test_sync_discard();
    test_valid_toggle();
    test_overflow();
    test_zero_window();
    test_baseline();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
